// File: rtl/enc8t3_pkg.sv
// Shared constants and types for the 8-to-3 sequential priority encoder.
package enc8t3_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;

  typedef logic [N_LINES-1:0] line_vec_t;
  typedef logic [CODE_W-1:0]  code_t;

  // One-hot mask for a line index, used to retire the issued line from pend.
  function automatic line_vec_t onehot(input code_t c);
    return line_vec_t'(1) << c;
  endfunction

endpackage

// File: rtl/enc8t3_prio.sv
// Combinational pick of one set bit from an 8-bit vector.
// Search order is start-1, start-2, ... descending with wrap, start itself last.
// With start=0 this reduces to plain highest-index-wins priority.
module enc8t3_prio
  import enc8t3_pkg::*;
(
  input  line_vec_t vec,
  input  code_t     start,
  output code_t     sel,
  output logic      any
);

  code_t idx;

  // Walk the order backwards so the earliest candidate in search order is the last write.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N_LINES; k >= 1; k--) begin
      idx = code_t'(start - code_t'(k));
      if (vec[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc8t3_seq.sv
// Sequential 8-to-3 priority encoder with valid/ready output.
// Request strobes are merged into a pending register; one pending line is
// issued per free output slot and retired from pend as it issues.
// Optional macro ENC8T3_RR_EN: round-robin selection starting below the last
// issued line; otherwise fixed highest-index priority.
module enc8t3_seq
  import enc8t3_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  line_vec_t req,
  output code_t     code,
  output logic      valid,
  input  logic      ready,
  output line_vec_t pend,
  output logic      ovf
);

  line_vec_t cap, cand;
  logic      slot_free;
  code_t     sel, start;
  logic      any;

  assign cap       = en ? req : '0;
  assign cand      = pend | cap;
  assign slot_free = ~valid | ready;

`ifdef ENC8T3_RR_EN
  code_t ptr;
  assign start = ptr;

  // Round-robin pointer follows the most recently issued line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                ptr <= '0;
    else if (slot_free && any) ptr <= sel;
  end
`else
  assign start = '0;
`endif

  enc8t3_prio u_prio (
    .vec   (cand),
    .start (start),
    .sel   (sel),
    .any   (any)
  );

  // Issue/hold the output slot and keep the pending set; ovf flags merged strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= '0;
      code  <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      ovf <= |(cap & pend);
      if (slot_free) begin
        if (any) begin
          code  <= sel;
          valid <= 1'b1;
          pend  <= cand & ~onehot(sel);
        end else begin
          valid <= 1'b0;
          pend  <= '0;
        end
      end else begin
        pend <= cand;
      end
    end
  end

endmodule

// File: tb/tb_enc8t3_seq.sv
// Self-checking bench for enc8t3_seq: directed scenarios plus randomized traffic
// checked against a set-based reference model of the pending lines.
module tb_enc8t3_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       ready;
  logic [7:0] req;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pend;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_pending [8];
  int m_code;
  bit m_valid;
  bit m_ovf;
  int m_ptr;

`ifdef ENC8T3_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  enc8t3_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .code  (code),
    .valid (valid),
    .ready (ready),
    .pend  (pend),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pending[i];
    return v;
  endfunction

  // First pending line going downward from (last issued - 1), wrapping, last issued last.
  function automatic int m_pick(input bit c [8], input int after);
    for (int d = 1; d <= 8; d++) begin
      int line;
      line = (after + 8 - d) % 8;
      if (c[line]) return line;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pending[i] = 1'b0;
    m_code = 0; m_valid = 1'b0; m_ovf = 1'b0; m_ptr = 0;
  endtask

  // Advance model and DUT by one edge with the currently driven inputs.
  task automatic step();
    bit c [8];
    bit hit;
    int s;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit r;
      r = en && req[i];
      if (r && m_pending[i]) hit = 1'b1;
      c[i] = m_pending[i] || r;
    end
    if (!m_valid || ready) begin
      s = m_pick(c, RR ? m_ptr : 0);
      if (s >= 0) begin
        m_code = s; m_valid = 1'b1; m_ptr = s; c[s] = 1'b0;
        m_pending = c;
      end else begin
        m_valid = 1'b0;
        for (int i = 0; i < 8; i++) m_pending[i] = 1'b0;
      end
    end else begin
      m_pending = c;
    end
    m_ovf = hit;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; req = '0; ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({valid, code, pend, ovf} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got v=%0b c=%0d p=%h o=%0b want all zero", valid, code, pend, ovf);
    end
  endtask

  task automatic test_single();
    apply_reset();
    en = 1'b1; req = 8'h20; ready = 1'b1; step();
    checks++;
    if (valid !== 1'b1 || code !== 3'd5 || pend !== 8'h00) begin
      errors++;
      $display("FAIL single_issue got v=%0b c=%0d p=%h want v=1 c=5 p=00", valid, code, pend);
    end
    req = '0; step();
    checks++;
    if (valid !== 1'b0 || pend !== 8'h00 || code !== 3'd5) begin
      errors++;
      $display("FAIL single_drain got v=%0b c=%0d p=%h want v=0 c=5 p=00", valid, code, pend);
    end
  endtask

  task automatic test_multi_hot();
    apply_reset();
    en = 1'b1; req = 8'h81; ready = 1'b1; step();
    checks++;
    if (valid !== 1'b1 || code !== 3'd7 || pend !== 8'h01) begin
      errors++;
      $display("FAIL multi_first got v=%0b c=%0d p=%h want v=1 c=7 p=01", valid, code, pend);
    end
    req = '0; step();
    checks++;
    if (valid !== 1'b1 || code !== 3'd0 || pend !== 8'h00) begin
      errors++;
      $display("FAIL multi_second got v=%0b c=%0d p=%h want v=1 c=0 p=00", valid, code, pend);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    en = 1'b1; req = 8'h0C; ready = 1'b0; step();
    req = '0; step(); step();
    checks++;
    if (valid !== 1'b1 || code !== 3'd3 || pend !== 8'h04) begin
      errors++;
      $display("FAIL stall_hold got v=%0b c=%0d p=%h want v=1 c=3 p=04", valid, code, pend);
    end
    ready = 1'b1; step();
    checks++;
    if (valid !== 1'b1 || code !== 3'd2 || pend !== 8'h00) begin
      errors++;
      $display("FAIL stall_release got v=%0b c=%0d p=%h want v=1 c=2 p=00", valid, code, pend);
    end
  endtask

  task automatic test_ovf_en();
    apply_reset();
    en = 1'b1; req = 8'h0C; ready = 1'b0; step();
    req = 8'h04; step();
    checks++;
    if (ovf !== 1'b1 || pend !== 8'h04) begin
      errors++;
      $display("FAIL ovf_pulse got o=%0b p=%h want o=1 p=04", ovf, pend);
    end
    req = '0; step();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_one_cycle got o=%0b want 0", ovf);
    end
    en = 1'b0; req = 8'hFF; step();
    checks++;
    if (ovf !== 1'b0 || pend !== 8'h04 || code !== 3'd3) begin
      errors++;
      $display("FAIL en_low got o=%0b p=%h c=%0d want o=0 p=04 c=3", ovf, pend, code);
    end
  endtask

  task automatic test_same_line();
    apply_reset();
    en = 1'b1; req = 8'h20; ready = 1'b0; step();
    step();  // re-request on held line: pend again, no overflow
    checks++;
    if (ovf !== 1'b0 || pend !== 8'h20 || code !== 3'd5) begin
      errors++;
      $display("FAIL held_line_rereq got o=%0b p=%h c=%0d want o=0 p=20 c=5", ovf, pend, code);
    end
    req = '0; ready = 1'b1; step();  // accept, pending copy issues
    req = 8'h20; step();             // accept + fresh request on the same line
    checks++;
    if (valid !== 1'b1 || code !== 3'd5 || ovf !== 1'b0 || pend !== 8'h00) begin
      errors++;
      $display("FAIL accept_rereq got v=%0b c=%0d o=%0b p=%h want v=1 c=5 o=0 p=00", valid, code, ovf, pend);
    end
  endtask

  task automatic test_rr();
    int exp_c [4];
    apply_reset();
    exp_c = RR ? '{7, 0, 7, 0} : '{7, 7, 7, 7};
    en = 1'b1; req = 8'h81; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || int'(code) != exp_c[i]) begin
        errors++;
        $display("FAIL rr_seq[%0d] got v=%0b c=%0d want v=1 c=%0d", i, valid, code, exp_c[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    en = 1'b1; req = 8'h0C; ready = 1'b0; step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, code, pend, ovf} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset got v=%0b c=%0d p=%h o=%0b want all zero", valid, code, pend, ovf);
    end
    model_reset();
    req = '0; en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      en    = ($urandom_range(0, 7) != 0);
      req   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ready = ($urandom_range(0, 3) != 0);
      step();
      checks++;
      if (valid !== m_valid || pend !== m_pend_vec() || ovf !== m_ovf ||
          (m_valid && int'(code) != m_code)) begin
        errors++;
        $display("FAIL random[%0d] got v=%0b c=%0d p=%h o=%0b want v=%0b c=%0d p=%h o=%0b",
                 n, valid, code, pend, ovf, m_valid, m_code, m_pend_vec(), m_ovf);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = '0; ready = 1'b0;
    test_reset();
    test_single();
    test_multi_hot();
    test_backpressure();
    test_ovf_en();
    test_same_line();
    test_rr();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc8t3_seq.md
Name: enc8t3_seq

Overview:
- Sequential 8-to-3 priority encoder: the encoding end of the team's 3-to-8 decoder path.
- Latches request strobes from 8 one-bit lines into a pending register. Presents the 3-bit index of one pending line at a time on a valid/ready output, and clears each line as it is issued.
- Drives the decoder/function-generator stage downstream, which consumes code and valid as its w/en inputs.

Parameters:
- None. Width is fixed at 8 lines / 3-bit code; constants live in the shared package.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  request capture enable; when 0, req is ignored and pending lines still drain
- req  input  8  request lines; multi-hot allowed; sampled each clk edge
- code  output  3  index of the issued request line
- valid  output  1  code holds an issued, unaccepted entry
- ready  input  1  consumer accepts; transfer when valid&&ready at clk edge
- pend  output  8  current pending register, for debug/status
- ovf  output  1  one-cycle pulse: a captured req bit hit a line already pending

Behaviour:
- Interface fixed: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, asynchronous): pend=8'h00, code=3'd0, valid=0, ovf=0, round-robin pointer=3'd0. No state survives a mid-operation reset; an unaccepted entry is discarded.
- Per edge:
  - cap = en ? req : 8'h00
  - cand = pend | cap
  - slot_free = ~valid | ready
- If slot_free and cand!=0:
  - sel = priority pick from cand
  - code<=sel, valid<=1
  - pend<=cand & ~(1<<sel)
- If slot_free and cand==0: valid<=0, code holds its last value, pend<=8'h00.
- If ~slot_free: code and valid hold, pend<=cand.
- Fixed priority: highest index wins (7 over 0).
- Latency: req high before edge t with empty pend and free slot gives valid=1, code=index right after edge t (1 cycle).
- Back-to-back: when ready is held high, one code issues per cycle with no bubble while cand!=0.
- Merge: a req on a line already pending is absorbed (no count) and ovf pulses high for the following cycle. Same for a req bit that hits a line in pend while the slot is stalled.
- A req on the line currently held in code (valid, unaccepted) sets pend again; the line is reported twice. This is not an overflow.
- ovf = |(cap & pend), registered; 0 otherwise.
- en=0 mid-stream: no new captures; existing pend drains normally.
- Simultaneous accept + new request on the accepted line: the new request is a fresh pending entry, not dropped.

Optional Feature:
- Macro: ENC8T3_RR_EN.
- Defined:
  - Round-robin selection; pointer ptr (reset 0) updated to sel on each issue.
  - Search order is ptr-1, ptr-2, … descending with wrap modulo 8, ptr itself last.
  - After reset the order is 7..0, identical to fixed priority.
- Undefined: fixed highest-index priority; no ptr register.

Decomposition:
- Package enc8t3_pkg:
  - N_LINES=8, CODE_W=3
  - typedef line_vec_t (8-bit)
  - typedef code_t (3-bit)
- One natural sub-module, enc8t3_prio: purely combinational pick of sel and any-bit from an 8-bit vector plus a 3-bit start pointer. Start is tied to 0 when ENC8T3_RR_EN is undefined.

Test Plan:
- Reset check: rst_n low mid-stream with valid=1 → valid=0, pend=00, code=0 immediately (async), ovf=0.
- Single request: en=1, req=8'h20 for one cycle, ready=1 → next cycle code=5, valid=1; following cycle valid=0, pend=00.
- Multi-hot: req=8'h81 once, ready=1 → code 7 then 0 on consecutive cycles; pend 01 then 00.
- Backpressure: req=8'h0C, ready=0 for 3 cycles → code=3 held, pend=04. Then ready=1 → code=2 next cycle.
- Overflow and en: pend=04 stalled, req=8'h04 → ovf pulses one cycle, pend stays 04. With en=0, req=FF → pend unchanged, no ovf.
- ENC8T3_RR_EN: hold req=8'h81 every cycle, ready=1 → codes alternate 7,0,7,0. Without the macro → codes 7,7,7 with line 0 starved.
